mining_controller: RTL

- Sequences one nonce-search job across the message preprocessor and the SHA-256 compression core.
- Per nonce:
  - substitutes the nonce into the header;
  - pulses the preprocessor and waits for its done;
  - feeds each padded 512-bit chunk to the SHA core in order;
  - compares the digest against the target.
- Iterates nonces until a hit, nonce exhaustion, or abort.
- Sits between the top-level host interface and the preprocessor/SHA datapath.

---
 rtl/mining_pkg.sv | 34 +++
 rtl/nonce_iterator.sv | 51 +++++
 rtl/mining_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mining_pkg.sv
// mining_pkg: shared types and constants for the nonce-search controller.
//   ctrl_state_t  - controller FSM states
//   DIGEST_W      - SHA-256 digest width
//   CHUNK_W       - padded message chunk width
//   chunk_pair_t  - two padded chunks, [1] is the upper 512 bits
//   select_chunk  - picks the chunk to compress for a given chunk index
package mining_pkg;

   localparam int DIGEST_W = 256;
   localparam int CHUNK_W  = 512;

   typedef logic [1:0][CHUNK_W-1:0] chunk_pair_t;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_PRE_START = 4'd1,
      ST_PRE_WAIT  = 4'd2,
      ST_SHA_START = 4'd3,
      ST_SHA_WAIT  = 4'd4,
      ST_COMPARE   = 4'd5,
      ST_NEXT      = 4'd6,
      ST_FOUND     = 4'd7,
      ST_EXHAUSTED = 4'd8
   } ctrl_state_t;

   // Chunks are fed from the last valid one downwards: index = last - chunk.
   // With one-bit last/chunk that difference is last & ~chunk.
   function automatic logic [CHUNK_W-1:0] select_chunk(input chunk_pair_t blocks,
                                                      input logic        last,
                                                      input logic        chunk);
      return blocks[last & ~chunk];
   endfunction

endpackage

// File: rtl/nonce_iterator.sv
// nonce_iterator: holds the current nonce of a search job.
//   clk, rst    - clock, synchronous active-high reset
//   load        - load load_value as the starting nonce
//   load_value  - starting nonce
//   incr        - advance to the next nonce
//   nonce       - current nonce (registered)
//   last_nonce  - current nonce is all-ones (registered)
module nonce_iterator #(
   parameter int NONCE_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [NONCE_W-1:0] load_value,
   input  logic               incr,
   output logic [NONCE_W-1:0] nonce,
   output logic               last_nonce
);

   logic [NONCE_W-1:0] nonce_r;
   logic [NONCE_W-1:0] nonce_nxt_s;
   logic               last_r;

   // Next nonce: load takes priority over increment.
   always_comb begin
      nonce_nxt_s = nonce_r;
      if (load) begin
         nonce_nxt_s = load_value;
      end else if (incr) begin
         nonce_nxt_s = nonce_r + {{(NONCE_W-1){1'b0}}, 1'b1};
      end else begin
         nonce_nxt_s = nonce_r;
      end
   end

   // Nonce register; the last-nonce flag is derived from the next value so it
   // is aligned with the nonce it describes.
   always_ff @(posedge clk) begin
      if (rst) begin
         nonce_r <= {NONCE_W{1'b0}};
         last_r  <= 1'b0;
      end else begin
         nonce_r <= nonce_nxt_s;
         last_r  <= (nonce_nxt_s == {NONCE_W{1'b1}});
      end
   end

   assign nonce      = nonce_r;
   assign last_nonce = last_r;

endmodule

// File: rtl/mining_controller.sv
// mining_controller: runs one nonce search job over the preprocessor and the
// SHA-256 compression core, stopping on a hit, nonce exhaustion or abort.
//   clk, rst                  - clock, synchronous active-high reset
//   start, abort              - job control from the host
//   header_in, target         - header template (low bits = start nonce), threshold
//   pre_msg, pre_begin        - header with current nonce, preprocess pulse
//   pre_done, pre_position,
//   pre_blocks                - preprocessor result (last chunk index, chunks)
//   sha_start, sha_first,
//   sha_block                 - compression request (first = load IV)
//   sha_done, sha_digest      - compression result
//   busy, found, exhausted    - job status
//   nonce_out, hash_out       - winning nonce and digest
module mining_controller
   import mining_pkg::*;
#(
   parameter int MESSAGE_SIZE = 640,
   parameter int NONCE_W      = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [MESSAGE_SIZE-1:0] header_in,
   input  logic [DIGEST_W-1:0]     target,
   output logic [MESSAGE_SIZE-1:0] pre_msg,
   output logic                    pre_begin,
   input  logic                    pre_done,
   input  logic [1:0]              pre_position,
   input  chunk_pair_t             pre_blocks,
   output logic                    sha_start,
   output logic                    sha_first,
   output logic [CHUNK_W-1:0]      sha_block,
   input  logic                    sha_done,
   input  logic [DIGEST_W-1:0]     sha_digest,
   output logic                    busy,
   output logic                    found,
   output logic                    exhausted,
   output logic [NONCE_W-1:0]      nonce_out,
   output logic [DIGEST_W-1:0]     hash_out
);

   ctrl_state_t state_r;
   ctrl_state_t state_nxt_s;

   logic [MESSAGE_SIZE-NONCE_W-1:0] header_hi_r;
   logic [DIGEST_W-1:0]             target_r;
   logic [DIGEST_W-1:0]             digest_r;
   chunk_pair_t                     blocks_r;
   logic                            last_r;
   logic                            chunk_r;

   chunk_pair_t                     blocks_nxt_s;
   logic                            last_nxt_s;
   logic                            chunk_nxt_s;

   logic                            capture_s;
   logic                            latch_pre_s;
   logic                            chunk_inc_s;
   logic                            latch_dig_s;
   logic                            hit_take_s;
   logic                            incr_s;
   logic                            hit_s;

   logic [NONCE_W-1:0]              nonce_s;
   logic                            last_nonce_s;

   logic                            pre_begin_r;
   logic                            sha_start_r;
   logic                            sha_first_r;
   logic [CHUNK_W-1:0]              sha_block_r;
   logic                            busy_r;
   logic                            found_r;
   logic                            exhausted_r;
   logic [NONCE_W-1:0]              nonce_out_r;
   logic [DIGEST_W-1:0]             hash_out_r;

   nonce_iterator #(
      .NONCE_W (NONCE_W)
   ) u_nonce (
      .clk        (clk),
      .rst        (rst),
      .load       (capture_s),
      .load_value (header_in[NONCE_W-1:0]),
      .incr       (incr_s),
      .nonce      (nonce_s),
      .last_nonce (last_nonce_s)
   );

   // Next-state and control strobes; abort outranks every handshake.
   always_comb begin
      state_nxt_s = state_r;
      capture_s   = 1'b0;
      latch_pre_s = 1'b0;
      chunk_inc_s = 1'b0;
      latch_dig_s = 1'b0;
      hit_take_s  = 1'b0;
      incr_s      = 1'b0;
      hit_s       = (digest_r < target_r);
      if ((state_r != ST_IDLE) && abort) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  capture_s   = 1'b1;
                  state_nxt_s = ST_PRE_START;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_PRE_START: state_nxt_s = ST_PRE_WAIT;
            ST_PRE_WAIT: begin
               if (pre_done) begin
                  latch_pre_s = 1'b1;
                  state_nxt_s = ST_SHA_START;
               end else begin
                  state_nxt_s = ST_PRE_WAIT;
               end
            end
            ST_SHA_START: state_nxt_s = ST_SHA_WAIT;
            ST_SHA_WAIT: begin
               if (sha_done && (chunk_r < last_r)) begin
                  chunk_inc_s = 1'b1;
                  state_nxt_s = ST_SHA_START;
               end else if (sha_done) begin
                  latch_dig_s = 1'b1;
                  state_nxt_s = ST_COMPARE;
               end else begin
                  state_nxt_s = ST_SHA_WAIT;
               end
            end
            ST_COMPARE: begin
               if (hit_s) begin
                  hit_take_s  = 1'b1;
                  state_nxt_s = ST_FOUND;
               end else if (last_nonce_s) begin
                  state_nxt_s = ST_EXHAUSTED;
               end else begin
                  state_nxt_s = ST_NEXT;
               end
            end
            ST_NEXT: begin
               incr_s      = 1'b1;
               state_nxt_s = ST_PRE_START;
            end
            ST_FOUND:     state_nxt_s = ST_IDLE;
            ST_EXHAUSTED: state_nxt_s = ST_IDLE;
            default:      state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Next values of the chunk bookkeeping, needed early so the SHA request
   // outputs can be registered on the edge that enters SHA_START.
   always_comb begin
      blocks_nxt_s = blocks_r;
      last_nxt_s   = last_r;
      chunk_nxt_s  = chunk_r;
      if (latch_pre_s) begin
         blocks_nxt_s = pre_blocks;
         last_nxt_s   = (pre_position != 2'd0);
         chunk_nxt_s  = 1'b0;
      end else if (chunk_inc_s) begin
         chunk_nxt_s  = chunk_r + 1'b1;
      end else begin
         chunk_nxt_s  = chunk_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Job datapath registers and registered outputs, all keyed off the next state
   // so each pulse is high exactly while the FSM sits in its issuing state.
   always_ff @(posedge clk) begin
      if (rst) begin
         header_hi_r <= {(MESSAGE_SIZE-NONCE_W){1'b0}};
         target_r    <= {DIGEST_W{1'b0}};
         digest_r    <= {DIGEST_W{1'b0}};
         blocks_r    <= {(2*CHUNK_W){1'b0}};
         last_r      <= 1'b0;
         chunk_r     <= 1'b0;
         pre_begin_r <= 1'b0;
         sha_start_r <= 1'b0;
         sha_first_r <= 1'b0;
         sha_block_r <= {CHUNK_W{1'b0}};
         busy_r      <= 1'b0;
         found_r     <= 1'b0;
         exhausted_r <= 1'b0;
         nonce_out_r <= {NONCE_W{1'b0}};
         hash_out_r  <= {DIGEST_W{1'b0}};
      end else begin
         if (capture_s) begin
            header_hi_r <= header_in[MESSAGE_SIZE-1:NONCE_W];
            target_r    <= target;
         end
         if (latch_dig_s) begin
            digest_r <= sha_digest;
         end
         blocks_r    <= blocks_nxt_s;
         last_r      <= last_nxt_s;
         chunk_r     <= chunk_nxt_s;
         pre_begin_r <= (state_nxt_s == ST_PRE_START);
         sha_start_r <= (state_nxt_s == ST_SHA_START);
         sha_first_r <= (state_nxt_s == ST_SHA_START) && (chunk_nxt_s == 1'b0);
         if (state_nxt_s == ST_SHA_START) begin
            sha_block_r <= select_chunk(blocks_nxt_s, last_nxt_s, chunk_nxt_s);
         end
         busy_r <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_FOUND) &&
                   (state_nxt_s != ST_EXHAUSTED);
         if (capture_s) begin
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
         end else begin
            if (hit_take_s) begin
               found_r <= 1'b1;
            end
            if (state_nxt_s == ST_EXHAUSTED) begin
               exhausted_r <= 1'b1;
            end
         end
         if (hit_take_s) begin
            nonce_out_r <= nonce_s;
            hash_out_r  <= digest_r;
         end
      end
   end

   assign pre_msg   = {header_hi_r, nonce_s};
   assign pre_begin = pre_begin_r;
   assign sha_start = sha_start_r;
   assign sha_first = sha_first_r;
   assign sha_block = sha_block_r;
   assign busy      = busy_r;
   assign found     = found_r;
   assign exhausted = exhausted_r;
   assign nonce_out = nonce_out_r;
   assign hash_out  = hash_out_r;

endmodule
